util_cpack2_timestamp_v2: RTL and testbench

Single-clock, parametrised timestamp inserter between `util_cpack2` and the ADC DMA write FIFO. Every `timestamp_every` accepted packed words, it emits one header word carrying the timestamp captured when the block's first data word arrived. A local elastic FIFO absorbs the extra header cycle, so no second clock is needed. The block drops words on FIFO full, reports the drop as overflow, and forces a fresh header so downstream can resynchronise.

---
 rtl/util_cpack2_timestamp_pkg.sv | 24 ++
 rtl/util_cpack2_timestamp_fifo.sv | 46 ++++
 rtl/util_cpack2_timestamp_v2.sv | 161 ++++++++++++++++
 tb/tb_util_cpack2_timestamp_v2.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/util_cpack2_timestamp_pkg.sv
// Shared types and width helpers for the cpack2 timestamp inserter.
package util_cpack2_timestamp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA
  } state_t;

  function automatic int calc_w(input int num_ch, input int sample_w, input int samples_per_ch);
    return num_ch * sample_w * samples_per_ch;
  endfunction

  // Entry layout, MSB first: {first, sync, data, timestamp}.
  function automatic int entry_width(input int w, input int ts_w);
    return 2 + w + ts_w;
  endfunction

  // Header word is the timestamp zero-extended on the left to the data width.
  function automatic int pad_width(input int w, input int ts_w);
    return w - ts_w;
  endfunction

endpackage

// File: rtl/util_cpack2_timestamp_fifo.sv
// Single-clock show-ahead FIFO; full blocks pushes even when a pop happens on the same edge.
module util_cpack2_timestamp_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_push;
  logic                w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
  end

endmodule

// File: rtl/util_cpack2_timestamp_v2.sv
// Inserts a timestamp header word ahead of every block of timestamp_every packed words.
module util_cpack2_timestamp_v2
  import util_cpack2_timestamp_pkg::*;
#(
  parameter int NUM_OF_CHANNELS     = 4,
  parameter int SAMPLE_DATA_WIDTH   = 16,
  parameter int SAMPLES_PER_CHANNEL = 1,
  parameter int TIMESTAMP_WIDTH     = 64,
  parameter int FIFO_DEPTH_LOG2     = 4,
  localparam int W = calc_w(NUM_OF_CHANNELS, SAMPLE_DATA_WIDTH, SAMPLES_PER_CHANNEL)
) (
  input  logic                       adc_clk,
  input  logic                       adc_rst,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic [31:0]                timestamp_every,
  input  logic                       packed_fifo_wr_en,
  input  logic                       packed_fifo_wr_sync,
  input  logic [W-1:0]               packed_fifo_wr_data,
  output logic                       packed_fifo_wr_overflow,
  output logic                       packed_timestamped_fifo_wr_en,
  output logic                       packed_timestamped_fifo_wr_sync,
  output logic [W-1:0]               packed_timestamped_fifo_wr_data,
  input  logic                       packed_timestamped_fifo_wr_overflow
);

  localparam int TSW   = TIMESTAMP_WIDTH;
  localparam int EW    = entry_width(W, TSW);
  localparam int PAD_W = pad_width(W, TSW);

  logic [31:0]    r_count;
  logic [31:0]    r_n;
  logic [31:0]    w_n_cur;
  logic           w_first;
  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_drop;
  logic           w_pop;
  logic [EW-1:0]  w_push_entry;
  logic [EW-1:0]  w_head;
  logic           w_head_first;
  logic           w_head_sync;
  logic [W-1:0]   w_head_data;
  logic [TSW-1:0] w_head_ts;
  logic [W-1:0]   w_header;

  state_t         r_state;
  state_t         w_next_state;
  logic           w_out_en;
  logic           w_out_sync;
  logic [W-1:0]   w_out_data;
  logic           r_out_en;
  logic           r_out_sync;
  logic [W-1:0]   r_out_data;
  logic           r_overflow;

  // ---------------- input side: block counter and N latch ----------------
  // A block boundary samples the live timestamp_every, so the first word of a block already obeys it.
  assign w_n_cur  = (r_count == '0) ? timestamp_every : r_n;
  assign w_first  = (r_count == '0) && (w_n_cur != '0);
  assign w_drop   = packed_fifo_wr_en && w_full;
  assign w_accept = packed_fifo_wr_en && !w_full;
  assign w_push_entry = {w_first, packed_fifo_wr_sync, packed_fifo_wr_data, timestamp};

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_count <= '0;
      r_n     <= '0;
    end else if (w_drop) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (r_count == '0) r_n <= timestamp_every;
      if ((w_n_cur == '0) || (r_count == w_n_cur - 32'd1)) r_count <= '0;
      else                                                  r_count <= r_count + 32'd1;
    end
  end

  util_cpack2_timestamp_fifo #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (adc_clk),
    .i_rst   (adc_rst),
    .i_push  (packed_fifo_wr_en),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_first, w_head_sync, w_head_data, w_head_ts} = w_head;

  if (PAD_W > 0) begin : g_pad
    assign w_header = {{PAD_W{1'b0}}, w_head_ts};
  end else begin : g_nopad
    assign w_header = w_head_ts;
  end

  // ---------------- output side: FSM state names what is on the outputs ----------------
  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_out_en     = 1'b0;
    w_out_sync   = 1'b0;
    w_out_data   = '0;
    case (r_state)
      ST_HEADER: begin
        // Header was shown last cycle; the same head entry now goes out as data.
        w_out_en     = 1'b1;
        w_out_sync   = w_head_sync;
        w_out_data   = w_head_data;
        w_pop        = 1'b1;
        w_next_state = ST_DATA;
      end
      default: begin
        if (w_empty) begin
          w_next_state = ST_IDLE;
        end else if (w_head_first) begin
          w_out_en     = 1'b1;
          w_out_sync   = 1'b1;
          w_out_data   = w_header;
          w_next_state = ST_HEADER;
        end else begin
          w_out_en     = 1'b1;
          w_out_sync   = w_head_sync;
          w_out_data   = w_head_data;
          w_pop        = 1'b1;
          w_next_state = ST_DATA;
        end
      end
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      r_out_en   <= 1'b0;
      r_out_sync <= 1'b0;
      r_out_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_out_en   <= w_out_en;
      r_out_sync <= w_out_sync;
      r_out_data <= w_out_data;
      r_overflow <= w_drop | packed_timestamped_fifo_wr_overflow;
    end
  end

  assign packed_timestamped_fifo_wr_en   = r_out_en;
  assign packed_timestamped_fifo_wr_sync = r_out_sync;
  assign packed_timestamped_fifo_wr_data = r_out_data;
  assign packed_fifo_wr_overflow         = r_overflow;

endmodule

// File: tb/tb_util_cpack2_timestamp_v2.sv
// Directed bench: pass-through, header insertion, full/drop, mode change, reset, downstream overflow.
module tb_util_cpack2_timestamp_v2;

  logic        adc_clk = 1'b0;
  logic        adc_rst;
  logic [47:0] timestamp;
  logic [31:0] timestamp_every;
  logic        in_en;
  logic        in_sync;
  logic [63:0] in_data;
  logic        up_ovf;
  logic        out_en;
  logic        out_sync;
  logic [63:0] out_data;
  logic        ds_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] ts;
  logic [63:0] q_data[$];
  logic        q_sync[$];
  logic [63:0] e_data[$];
  logic        e_sync[$];

  always #5 adc_clk = ~adc_clk;

  util_cpack2_timestamp_v2 #(
    .NUM_OF_CHANNELS     (4),
    .SAMPLE_DATA_WIDTH   (16),
    .SAMPLES_PER_CHANNEL (1),
    .TIMESTAMP_WIDTH     (48),
    .FIFO_DEPTH_LOG2     (2)
  ) dut (
    .adc_clk                             (adc_clk),
    .adc_rst                             (adc_rst),
    .timestamp                           (timestamp),
    .timestamp_every                     (timestamp_every),
    .packed_fifo_wr_en                   (in_en),
    .packed_fifo_wr_sync                 (in_sync),
    .packed_fifo_wr_data                 (in_data),
    .packed_fifo_wr_overflow             (up_ovf),
    .packed_timestamped_fifo_wr_en       (out_en),
    .packed_timestamped_fifo_wr_sync     (out_sync),
    .packed_timestamped_fifo_wr_data     (out_data),
    .packed_timestamped_fifo_wr_overflow (ds_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, sample outputs 1 time unit after the edge, advance the timestamp.
  task automatic cyc(input logic en, input logic sy, input logic [63:0] d);
    in_en   = en;
    in_sync = sy;
    in_data = d;
    @(posedge adc_clk);
    #1;
    if (out_en === 1'b1) begin
      q_data.push_back(out_data);
      q_sync.push_back(out_sync);
    end
    ts        = ts + 48'd1;
    timestamp = ts;
    in_en     = 1'b0;
    in_sync   = 1'b0;
    in_data   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 64'h0);
  endtask

  // Push one word; if accepted, record the expected header (timestamp at this push edge) and data.
  task automatic push_word(input logic [63:0] d, input logic sy, input logic hdr, input logic acc);
    if (acc) begin
      if (hdr) begin
        e_data.push_back({16'h0, ts});
        e_sync.push_back(1'b1);
      end
      e_data.push_back(d);
      e_sync.push_back(sy);
    end
    cyc(1'b1, sy, d);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_count"}, 64'(q_data.size()), 64'(e_data.size()));
    n = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), q_data[i], e_data[i]);
      check($sformatf("%s_sync[%0d]", tag, i), 64'(q_sync[i]), 64'(e_sync[i]));
    end
    q_data.delete();
    q_sync.delete();
    e_data.delete();
    e_sync.delete();
  endtask

  initial begin
    adc_rst         = 1'b1;
    ts              = 48'd100;
    timestamp       = ts;
    timestamp_every = 32'd0;
    in_en           = 1'b0;
    in_sync         = 1'b0;
    in_data         = '0;
    ds_ovf          = 1'b0;

    repeat (3) @(posedge adc_clk);
    #1;
    check("reset_en",   64'(out_en),   64'h0);
    check("reset_sync", 64'(out_sync), 64'h0);
    check("reset_data", out_data,      64'h0);
    check("reset_ovf",  64'(up_ovf),   64'h0);
    @(negedge adc_clk);
    adc_rst = 1'b0;

    // Pass-through, N=0, 1-in-4 duty; first word checks single-cycle latency.
    timestamp_every = 32'd0;
    push_word(64'h0004_0003_0002_0001, 1'b1, 1'b0, 1'b1);
    check("pt_lat_edge_k", 64'(out_en), 64'h0);
    idle(1);
    check("pt_lat_en",   64'(out_en), 64'h1);
    check("pt_lat_data", out_data,    64'h0004_0003_0002_0001);
    idle(2);
    for (int i = 1; i < 4; i++) begin
      push_word(64'h0004_0003_0002_0001 + 64'(i) * 64'h0004_0004_0004_0004, 1'b0, 1'b0, 1'b1);
      idle(3);
    end
    idle(4);
    check_stream("pt");

    // Insertion, N=4: 12 blocks of 4 words, one idle cycle per block.
    timestamp_every = 32'd4;
    for (int i = 0; i < 48; i++) begin
      push_word(64'hA000_0000_0000_0000 | 64'(i), 1'b0, (i % 4) == 0, 1'b1);
      if ((i % 4) == 3) idle(1);
    end
    idle(8);
    check_stream("ins");

    // Full/drop, N=1, depth 4, continuous input: drops on every even cycle from 6 onward.
    timestamp_every = 32'd1;
    for (int k = 0; k < 20; k++) begin
      push_word(64'hD000_0000_0000_0000 | 64'(k), 1'b0, 1'b1, (k < 6) || ((k % 2) == 1));
      check($sformatf("drop_ovf[%0d]", k), 64'(up_ovf), 64'((k >= 6) && ((k % 2) == 0)));
    end
    idle(12);
    check("drop_ovf_idle", 64'(up_ovf), 64'h0);
    check_stream("drop");

    // Mode change 4 -> 2 at word 2; downstream overflow pulse in the middle.
    timestamp_every = 32'd4;
    push_word(64'hC0, 1'b0, 1'b1, 1'b1); idle(1);
    push_word(64'hC1, 1'b0, 1'b0, 1'b1); idle(1);
    timestamp_every = 32'd2;
    push_word(64'hC2, 1'b1, 1'b0, 1'b1); idle(1);
    push_word(64'hC3, 1'b0, 1'b0, 1'b1); idle(1);
    push_word(64'hC4, 1'b0, 1'b1, 1'b1); idle(1);
    push_word(64'hC5, 1'b0, 1'b0, 1'b1);
    check("ds_ovf_before", 64'(up_ovf), 64'h0);
    ds_ovf = 1'b1;
    idle(1);
    ds_ovf = 1'b0;
    check("ds_ovf_pulse", 64'(up_ovf), 64'h1);
    idle(1);
    check("ds_ovf_after", 64'(up_ovf), 64'h0);
    push_word(64'hC6, 1'b0, 1'b1, 1'b1); idle(1);
    push_word(64'hC7, 1'b0, 1'b0, 1'b1);
    idle(6);
    check_stream("mode");

    // Reset mid-block at N=4 after 6 words.
    timestamp_every = 32'd4;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 64'hB0 + 64'(i));
    #2;
    adc_rst = 1'b1;
    #1;
    check("rst_mid_en",   64'(out_en),   64'h0);
    check("rst_mid_sync", 64'(out_sync), 64'h0);
    check("rst_mid_data", out_data,      64'h0);
    check("rst_mid_ovf",  64'(up_ovf),   64'h0);
    q_data.delete();
    q_sync.delete();
    #2;
    adc_rst = 1'b0;
    push_word(64'hE0, 1'b0, 1'b1, 1'b1);
    idle(5);
    check_stream("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
